// File: rtl/multiplier2_if.sv
// Multiply request/response bundle: operands and mode in, status and result out.
interface multiplier2_if;
    logic        ce;
    logic        start;
    logic        wide;
    logic        is_signed;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] product;

    modport master (
        output ce, start, wide, is_signed, a, b,
        input  busy, done, overflow, product
    );

    modport slave (
        input  ce, start, wide, is_signed, a, b,
        output busy, done, overflow, product
    );
endinterface

// File: rtl/multiplier2.sv
// Sequential shift-add multiplier, 16x16 or 8x8, signed or unsigned.
// Operands are converted to magnitudes on accept; the sign is reapplied in FIX.
module multiplier2 (
    input  logic          clk,
    input  logic          reset,
    multiplier2_if.slave  mul
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_mcand;
    logic [32:0] r_acc;      // {carry, upper half, multiplier / low product bits}
    logic [4:0]  r_cnt;
    logic        r_wide;
    logic        r_sgn;
    logic        r_neg;
    logic [31:0] r_product;
    logic        r_ovf;
    logic        r_done;

    logic        w_accept;
    logic        w_sa;
    logic        w_sb;
    logic [15:0] w_amag;
    logic [15:0] w_bmag;
    logic [16:0] w_sum;
    logic [32:0] w_acc_next;
    logic [31:0] w_raw;
    logic [31:0] w_final;
    logic        w_ovf;

    assign w_accept = mul.ce & mul.start;

    // Operand magnitudes; byte negation stays in 8 bits so 0x80 maps to 128
    always_comb begin
        w_sa = mul.is_signed & (mul.wide ? mul.a[15] : mul.a[7]);
        w_sb = mul.is_signed & (mul.wide ? mul.b[15] : mul.b[7]);
        if (mul.wide) begin
            w_amag = w_sa ? (~mul.a + 16'd1) : mul.a;
            w_bmag = w_sb ? (~mul.b + 16'd1) : mul.b;
        end else begin
            w_amag = {8'h00, (w_sa ? (~mul.a[7:0] + 8'd1) : mul.a[7:0])};
            w_bmag = {8'h00, (w_sb ? (~mul.b[7:0] + 8'd1) : mul.b[7:0])};
        end
    end

    // One shift-add step, plus final product alignment, sign and overflow.
    // After N right shifts the product sits at acc >> (16-N): byte results live in acc[23:8].
    always_comb begin
        w_sum      = r_acc[32:16] + {1'b0, r_mcand};
        w_acc_next = r_acc[0] ? {1'b0, w_sum, r_acc[15:1]} : {1'b0, r_acc[32:1]};
        w_raw      = r_wide ? r_acc[31:0] : {16'h0000, r_acc[23:8]};
        w_final    = r_neg ? (~w_raw + 32'd1) : w_raw;
        case ({r_wide, r_sgn})
            2'b10:   w_ovf = |w_final[31:16];
            2'b00:   w_ovf = |w_final[15:8];
            2'b11:   w_ovf = w_final[31:16] != {16{w_final[15]}};
            default: w_ovf = w_final[15:8] != {8{w_final[7]}};
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic: an accepted start restarts from any state
    always_comb begin
        w_next = r_state;
        if (w_accept) begin
            w_next = RUN;
        end else if (mul.ce) begin
            case (r_state)
                RUN:     if (r_cnt == 5'd1) w_next = FIX;
                FIX:     w_next = IDLE;
                default: w_next = r_state;
            endcase
        end
    end

    // Output logic
    always_comb begin
        mul.busy     = (r_state == RUN) || (r_state == FIX);
        mul.done     = r_done & ~mul.start;
        mul.overflow = r_ovf;
        mul.product  = r_product;
    end

    // Datapath: load on accept, iterate in RUN, write result in FIX
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_wide    <= 1'b0;
            r_sgn     <= 1'b0;
            r_neg     <= 1'b0;
            r_product <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else if (mul.ce) begin
            if (mul.start) begin
                r_mcand <= w_amag;
                r_acc   <= {17'd0, w_bmag};
                r_cnt   <= mul.wide ? 5'd16 : 5'd8;
                r_wide  <= mul.wide;
                r_sgn   <= mul.is_signed;
                r_neg   <= w_sa ^ w_sb;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    RUN: begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt - 5'd1;
                    end
                    FIX: begin
                        r_product <= w_final;
                        r_ovf     <= w_ovf;
                        r_done    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multiplier2.sv
// Self-checking bench for multiplier2: arithmetic reference model plus directed cases.
module tb_multiplier2;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    multiplier2_if mif ();

    multiplier2 dut (
        .clk   (clk),
        .reset (reset),
        .mul   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result from plain integer arithmetic
    task automatic model_calc(input logic w, input logic s, input logic [15:0] a,
                              input logic [15:0] b, output logic [31:0] p, output logic o);
        longint av, bv, r;
        logic [7:0] a8, b8;
        a8 = a[7:0];
        b8 = b[7:0];
        if (w) begin
            av = s ? longint'($signed(a)) : longint'(a);
            bv = s ? longint'($signed(b)) : longint'(b);
        end else begin
            av = s ? longint'($signed(a8)) : longint'(a8);
            bv = s ? longint'($signed(b8)) : longint'(b8);
        end
        r = av * bv;
        p = r[31:0];
        if (w) o = s ? (r < -32768 || r > 32767) : (r > 65535);
        else   o = s ? (r < -128 || r > 127) : (r > 255);
    endtask

    // Model state: pending operation and the ce-qualified edges it still needs
    logic        m_valid;
    logic        m_pending;
    int          m_left;
    logic [31:0] m_res;
    logic        m_res_ovf;
    logic        m_done;
    logic [31:0] m_prod;
    logic        m_ovf;

    initial begin
        m_valid   = 1'b0;
        m_pending = 1'b0;
        m_left    = 0;
        m_done    = 1'b0;
        m_prod    = '0;
        m_ovf     = 1'b0;
        m_res     = '0;
        m_res_ovf = 1'b0;
    end

    // Update the model on every edge, then compare the DUT just after it
    always @(posedge clk) begin
        if (reset) begin
            m_valid   = 1'b1;
            m_pending = 1'b0;
            m_left    = 0;
            m_done    = 1'b0;
            m_prod    = '0;
            m_ovf     = 1'b0;
        end else if (mif.ce) begin
            if (mif.start) begin
                model_calc(mif.wide, mif.is_signed, mif.a, mif.b, m_res, m_res_ovf);
                m_pending = 1'b1;
                m_left    = mif.wide ? 17 : 9;
                m_done    = 1'b0;
            end else if (m_pending) begin
                m_left--;
                if (m_left == 0) begin
                    m_pending = 1'b0;
                    m_done    = 1'b1;
                    m_prod    = m_res;
                    m_ovf     = m_res_ovf;
                end
            end
        end
        #1;
        if (m_valid) begin
            chk("busy", 32'(mif.busy), 32'(m_pending));
            chk("done", 32'(mif.done), 32'(m_done & ~mif.start));
            chk("product", mif.product, m_prod);
            chk("overflow", 32'(mif.overflow), 32'(m_ovf));
        end
    end

    // One operation; lat is the number of edges after the accepting edge until done
    task automatic run_op(input string nm, input logic w, input logic s, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] ep, input logic eo,
                          input int lat, input bit tog);
        int cnt;
        int busy_cnt;
        @(negedge clk);
        mif.wide = w; mif.is_signed = s; mif.a = a; mif.b = b;
        mif.start = 1'b1; mif.ce = 1'b1;
        @(posedge clk); #1;
        busy_cnt = mif.busy ? 1 : 0;
        @(negedge clk);
        mif.start = 1'b0;
        if (tog) mif.ce = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (mif.done) break;
            if (mif.busy) busy_cnt++;
            @(negedge clk);
            if (tog) mif.ce = ~mif.ce;
        end
        chk({nm, "_latency"}, 32'(cnt), 32'(lat));
        chk({nm, "_product"}, mif.product, ep);
        chk({nm, "_overflow"}, 32'(mif.overflow), 32'(eo));
        if (!tog) chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(lat));
        @(negedge clk);
        mif.ce = 1'b1;
    endtask

    // Start a wide 0xFFFF*0xFFFF, then restart d edges later with 3*4
    task automatic restart_op(input string nm, input int d);
        int cnt;
        @(negedge clk);
        mif.wide = 1'b1; mif.is_signed = 1'b0; mif.a = 16'hFFFF; mif.b = 16'hFFFF;
        mif.start = 1'b1; mif.ce = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.start = 1'b0;
        repeat (d - 1) @(posedge clk);
        @(negedge clk);
        mif.a = 16'h0003; mif.b = 16'h0004; mif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.start = 1'b0;
        cnt = d;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (mif.done) break;
        end
        chk({nm, "_done_edge"}, 32'(cnt), 32'(d + 17));
        chk({nm, "_product"}, mif.product, 32'h0000000C);
    endtask

    initial begin
        int seen;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        mif.ce = 1'b0; mif.start = 1'b0; mif.wide = 1'b0; mif.is_signed = 1'b0;
        mif.a = '0; mif.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(mif.busy), 32'd0);
        chk("reset_done", 32'(mif.done), 32'd0);
        chk("reset_product", mif.product, 32'd0);
        chk("reset_overflow", 32'(mif.overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mif.ce = 1'b1;

        run_op("u16_ffff",   1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1, 17, 1'b0);
        run_op("s16_m1x2",   1'b1, 1'b1, 16'hFFFF, 16'h0002, 32'hFFFFFFFE, 1'b0, 17, 1'b0);
        run_op("s16_min",    1'b1, 1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b1, 17, 1'b0);
        run_op("s8_m2x3",    1'b0, 1'b1, 16'h12FE, 16'hAB03, 32'hFFFFFFFA, 1'b0, 9, 1'b0);
        run_op("u8_10x10",   1'b0, 1'b0, 16'h0010, 16'h0010, 32'h00000100, 1'b1, 9, 1'b0);
        run_op("s8_upper",   1'b0, 1'b1, 16'hABFE, 16'h5503, 32'hFFFFFFFA, 1'b0, 9, 1'b0);
        run_op("s8_min",     1'b0, 1'b1, 16'h0080, 16'h0080, 32'h00004000, 1'b1, 9, 1'b0);
        run_op("s8_m128",    1'b0, 1'b1, 16'h0080, 16'h0001, 32'hFFFFFF80, 1'b0, 9, 1'b0);
        run_op("u16_cetog",  1'b1, 1'b0, 16'h1234, 16'h5678, 32'h06260060, 1'b1, 34, 1'b1);

        // start with ce low is ignored but masks done while high
        @(negedge clk);
        mif.ce = 1'b0; mif.start = 1'b1; mif.a = 16'h0005; mif.b = 16'h0007;
        @(posedge clk); #1;
        chk("ce0_start_done_masked", 32'(mif.done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        mif.start = 1'b0; mif.ce = 1'b1;
        @(posedge clk); #1;
        chk("ce0_start_done_back", 32'(mif.done), 32'd1);
        chk("ce0_start_product_held", mif.product, 32'h06260060);
        chk("ce0_start_not_busy", 32'(mif.busy), 32'd0);

        restart_op("restart_e5", 5);
        restart_op("restart_on_fix", 17);

        // reset mid-RUN
        @(negedge clk);
        mif.wide = 1'b1; mif.is_signed = 1'b0; mif.a = 16'h1111; mif.b = 16'h2222;
        mif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(mif.busy), 32'd0);
        chk("abort_done", 32'(mif.done), 32'd0);
        chk("abort_product", mif.product, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (mif.done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        run_op("after_reset", 1'b1, 1'b1, 16'hFFFF, 16'h0002, 32'hFFFFFFFE, 1'b0, 17, 1'b0);

        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/multiplier2.md
MULTIPLIER2 -- requirements
Module: multiplier2

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 16 bits and product width at 32 bits.
REQ-002 clk  input  1  The single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  Synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 ce  input  1  Clock enable; when low, all internal state SHALL hold.
REQ-005 start  input  1  Request a multiply; accepted on an edge where ce=1.
REQ-006 wide  input  1  1 = 16x16 multiply; 0 = 8x8 multiply using a[7:0] and b[7:0] only.
REQ-007 is_signed  input  1  1 = two's-complement operands; 0 = unsigned operands.
REQ-008 a  input  16  Multiplicand, sampled at the accepting edge.
REQ-009 b  input  16  Multiplier, sampled at the accepting edge.
REQ-010 busy  output  1  High while in state RUN or FIX.
REQ-011 done  output  1  Result valid; equals the registered done flag AND NOT start.
REQ-012 overflow  output  1  The result does not fit in the low half; valid while done=1.
REQ-013 product  output  32  Result; valid while done=1.

Function
REQ-014 The FSM SHALL have three states.
- IDLE: waiting for start.
- RUN: one shift-add iteration per ce-qualified edge.
- FIX: sign correction and output write.
REQ-015 Accepting edge (ce=1, start=1, any state) SHALL:
- load |a| and |b| as magnitudes; operands are negated only when is_signed=1 and the operand's MSB (bit 15 wide, bit 7 byte) is 1;
- latch wide, is_signed and result sign = sa XOR sb;
- clear accumulator and done flag;
- set iteration count N = 16 (wide) or 8 (byte);
- enter RUN.
REQ-016 Magnitudes SHALL be held unsigned so 0x8000 and 0x80 negate correctly to 32768 and 128.
REQ-017 RUN iteration: if multiplier LSB = 1, add the multiplicand into the upper accumulator with carry kept; then shift right one bit and decrement the count. The edge that completes iteration N SHALL enter FIX.
REQ-018 FIX edge SHALL:
- write product: the raw magnitude product, negated in 32 bits when the result sign is 1;
- set overflow;
- set the done flag;
- return to IDLE.
REQ-019 Byte mode: product[15:0] = the 16-bit result; product[31:16] = sign extension of product[15] when is_signed=1, else zero.
REQ-020 overflow SHALL be computed as follows.
- Unsigned wide: product[31:16] != 0.
- Unsigned byte: product[15:8] != 0.
- Signed wide: product[31:16] != 16 copies of product[15].
- Signed byte: product[15:8] != 8 copies of product[7].
REQ-021 Latency with ce held high, counted from the accepting edge E:
- wide: done=1 after edge E+17;
- byte: done=1 after edge E+9.
REQ-022 With ce low, state, count, product, overflow and the done flag SHALL all hold; latency extends by the number of ce-low cycles.
REQ-023 The done flag and product SHALL remain stable in IDLE until the next accepted start or reset.
REQ-024 start while busy (with ce=1) SHALL abort the current operation and restart with the new operands; no done is produced for the aborted operation.
REQ-025 start with ce=0 SHALL be ignored, but done SHALL still read 0 while start is high.
REQ-026 start and FIX on the same edge: start wins; the done flag stays 0 and a new operation begins.
REQ-027 Operand bits a[15:8] and b[15:8] SHALL have no effect in byte mode.

Reset
REQ-028 reset=1 SHALL have priority over ce and start, regardless of state, including mid-RUN.
REQ-029 On reset, the block SHALL:
- enter IDLE;
- set product=0, overflow=0, the done flag=0 and busy=0;
- clear the count and accumulator.
REQ-030 The first start accepted after reset deasserts SHALL behave as from power-up.

Verification
REQ-031 wide=1, is_signed=0, a=0xFFFF, b=0xFFFF, ce=1 -> product=0xFFFE0001, overflow=1, done rises after edge E+17, busy high for 17 cycles.
REQ-032 wide=1, is_signed=1, a=0xFFFF, b=0x0002 -> product=0xFFFFFFFE, overflow=0; then a=0x8000, b=0x8000 -> product=0x40000000, overflow=1.
REQ-033 wide=0, is_signed=1, a=0x12FE, b=0xAB03 -> product=0xFFFFFFFA, overflow=0, done after E+9; then wide=0, is_signed=0, a=0x0010, b=0x0010 -> product=0x00000100, overflow=1.
REQ-034 ce toggling 1,0,1,0 during a wide 0x1234 x 0x5678 unsigned multiply -> product=0x06260060, overflow=1, done after 17 ce-high edges (about 34 cycles).
REQ-035 Restart and reset cases:
- start at E, second start at E+5 with a=3, b=4 (wide, unsigned) -> single done at E+22, product=0x0000000C;
- reset asserted at E+8 -> busy=0, done=0, product=0 at the next edge, with no later done.
